// File: rtl/kyber_prod_pipe_pkg.sv
// kyber_pkg: shared Kyber constants, datapath widths and product-pipe state encoding.
package kyber_pkg;
    localparam int KYBER_Q = 3329;
    localparam int MONT    = -1044;
    localparam int QINV    = -3327;
    localparam int WIDTH   = 16;
    localparam int PWIDTH  = 32;
    localparam int TAGW    = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/kyber_prod_pipe_if.sv
// kyber_prod_pipe_if: coefficient-pair input stream and product/sum output stream.
interface kyber_prod_pipe_if;
    import kyber_pkg::*;
    logic                     in_valid, in_ready, in_acc, in_last;
    logic signed [WIDTH-1:0]  in_a, in_b;
    logic [TAGW-1:0]          in_tag;
    logic                     out_valid, out_ready;
    logic signed [PWIDTH-1:0] out_p;
    logic [TAGW-1:0]          out_tag;
    logic [15:0]              beat_cnt;
    modport slave (
        input  in_valid, in_a, in_b, in_acc, in_last, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, beat_cnt
    );
    modport master (
        output in_valid, in_a, in_b, in_acc, in_last, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, beat_cnt
    );
endinterface

// File: rtl/kyber_mul_stage.sv
// kyber_mul_stage: registered signed WIDTHxWIDTH multiplier with load enable.
module kyber_mul_stage import kyber_pkg::*; (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    output logic signed [PWIDTH-1:0] p
);
    logic signed [PWIDTH-1:0] ax, bx;
    assign ax = {{(PWIDTH-WIDTH){a[WIDTH-1]}}, a};
    assign bx = {{(PWIDTH-WIDTH){b[WIDTH-1]}}, b};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) p <= '0;
        else if (en) p <= ax * bx;
endmodule

// File: rtl/kyber_prod_pipe.sv
// kyber_prod_pipe: 2-stage signed product pipeline with optional running sum,
// feeding the Montgomery reducer; full-stall backpressure.
module kyber_prod_pipe import kyber_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    kyber_prod_pipe_if.slave io
);
    logic                     s1_valid, s1_acc, s1_last;
    logic signed [WIDTH-1:0]  s1_a, s1_b;
    logic [TAGW-1:0]          s1_tag, s2_tag, out_tag;
    logic                     s2_valid, s2_acc, s2_last, part;
    logic signed [PWIDTH-1:0] s2_p, sum, total, out_p;
    logic [15:0]              beat_cnt;
    state_t                   state;
    logic out_valid, out_fire, s2_adv, s2_free, s1_adv, in_fire, close;

    assign out_valid = state == HOLD;
    assign out_fire  = out_valid && io.out_ready;
    // non-last beats only touch the accumulator, so they never wait on the output
    assign s2_adv    = s2_valid && (!s2_last || !out_valid || io.out_ready);
    assign close     = s2_adv && s2_last;
    assign s2_free   = !s2_valid || s2_adv;
    assign s1_adv    = s1_valid && s2_free;
    assign in_fire   = io.in_valid && io.in_ready;
    assign total     = (s2_acc ? sum : '0) + s2_p;

    assign io.in_ready  = !s1_valid || s2_free;
    assign io.out_valid = out_valid;
    assign io.out_p     = out_p;
    assign io.out_tag   = out_tag;
    assign io.beat_cnt  = beat_cnt;

    kyber_mul_stage u_mul (
        .clk(clk), .rst_n(rst_n), .en(s1_adv), .a(s1_a), .b(s1_b), .p(s2_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_acc   <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_acc   <= 1'b0;
            s2_last  <= 1'b0;
            s2_tag   <= '0;
            sum      <= '0;
            part     <= 1'b0;
            out_p    <= '0;
            out_tag  <= '0;
            beat_cnt <= '0;
            state    <= IDLE;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_free);
            if (in_fire) {s1_a, s1_b, s1_acc, s1_last, s1_tag} <= {io.in_a, io.in_b, io.in_acc, io.in_last, io.in_tag};
            if (s2_free) s2_valid <= s1_valid;
            if (s1_adv) {s2_acc, s2_last, s2_tag} <= {s1_acc, s1_last, s1_tag};
            if (s2_adv) sum <= s2_last ? '0 : total;
            if (s2_adv) part <= !s2_last;
            if (close) {out_p, out_tag} <= {total, s2_tag};
            if (out_fire) beat_cnt <= beat_cnt + 16'd1;
            // a closing beat reloads HOLD even while the previous result drains
            state <= (close || (out_valid && !io.out_ready)) ? HOLD :
                     ((s2_adv ? !s2_last : part) ? ACCUM : IDLE);
        end
    end
endmodule

// File: tb/tb_kyber_prod_pipe.sv
// tb_kyber_prod_pipe: table-driven vectors plus scoreboard for kyber_prod_pipe.
module tb_kyber_prod_pipe;
    import kyber_pkg::*;

    typedef struct {int a; int b; bit acc; bit last; int tag; int exp;} vec_t;
    typedef struct {int p; int tag;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    kyber_prod_pipe_if bus();

    kyber_prod_pipe dut (.clk(clk), .rst_n(rst_n), .io(bus));

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   stalls = 0;
    bit   saw_stall = 0;
    exp_t q[$];
    vec_t tbl[12];

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    task automatic send(input int a, input int b, input bit acc, input bit last, input int tag, input int exp);
        bit rdy;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = WIDTH'(a);
        bus.in_b     = WIDTH'(b);
        bus.in_acc   = acc;
        bus.in_last  = last;
        bus.in_tag   = TAGW'(tag);
        if (last) q.push_back('{exp, tag});
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (!rdy) stalls++;
            n++;
        end while (!rdy && n < 1000);
        check("send_accept", rdy, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_acc = 0;
        bus.in_last = 0; bus.in_tag = 0; bus.out_ready = 1;
        tbl[0]  = '{-3328, 3328, 0, 1, 1, -11075584};
        tbl[1]  = '{-32768, -32768, 0, 1, 2, 1073741824};
        tbl[2]  = '{32767, -32768, 0, 1, 3, -1073709056};
        tbl[3]  = '{5, 7, 0, 0, 0, 0};
        tbl[4]  = '{-3, 4, 1, 1, 9, 23};
        tbl[5]  = '{2, 3, 0, 1, 4, 6};
        tbl[6]  = '{7, 8, 1, 1, 5, 56};
        tbl[7]  = '{100, 100, 0, 0, 0, 0};
        tbl[8]  = '{200, -50, 1, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 1, 6, 1};
        tbl[10] = '{9, 9, 0, 0, 0, 0};
        tbl[11] = '{2, 2, 0, 1, 8, 4};

        fork
            begin : monitor
                bit held = 0;
                int hp = 0, ht = 0;
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        held = 0;
                    end else begin
                        if (!bus.in_ready) saw_stall = 1;
                        if (bus.out_valid) begin
                            if (held) begin
                                check("hold_p", bus.out_p, hp);
                                check("hold_tag", bus.out_tag, ht);
                            end
                            if (bus.out_ready) begin
                                check("expected_pending", q.size() > 0, 1);
                                if (q.size() > 0) begin
                                    e = q.pop_front();
                                    check("out_p", bus.out_p, e.p);
                                    check("out_tag", bus.out_tag, e.tag);
                                end
                                held = 0;
                            end else begin
                                held = 1;
                                hp = bus.out_p;
                                ht = bus.out_tag;
                            end
                        end else held = 0;
                    end
                end
            end
        join_none

        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_p", bus.out_p, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_beat_cnt", bus.beat_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_in_ready", bus.in_ready, 1);

        send(1000, 2000, 0, 1, 5, 2000000);
        @(negedge clk) check("lat_c0", bus.out_valid, 0);
        @(negedge clk) check("lat_c1", bus.out_valid, 0);
        @(negedge clk) check("lat_c2", bus.out_valid, 1);
        check("lat_cnt_before", bus.beat_cnt, 0);
        @(posedge clk) #1 check("lat_cnt_after", bus.beat_cnt, 1);

        for (int i = 0; i < 12; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].last, tbl[i].tag, tbl[i].exp);
        drain();

        bus.out_ready = 0;
        saw_stall = 0;
        fork
            for (int i = 1; i <= 4; i++) send(i, i, 0, 1, 20 + i, i * i);
            begin
                int n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_out_valid_seen", bus.out_valid, 1);
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain();
        check("bp_in_ready_drop", saw_stall, 1);

        bus.out_ready = 0;
        send(2, 2, 0, 1, 3, 4);
        send(5, 7, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        check("mid_hold", bus.out_valid, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_p", bus.out_p, 0);
        check("mid_rst_beat_cnt", bus.beat_cnt, 0);
        q.delete();
        @(posedge clk) #1 rst_n = 1;
        bus.out_ready = 1;
        send(1, 1, 1, 1, 7, 1);
        drain();

        rst_n = 0;
        @(posedge clk) #1 rst_n = 1;
        stalls = 0;
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = int'($urandom_range(0, 6656)) - 3328;
            b = int'($urandom_range(0, 6656)) - 3328;
            send(a, b, 0, 1, i % 256, a * b);
        end
        drain();
        check("full_rate_stalls", stalls, 0);
        check("full_rate_beat_cnt", bus.beat_cnt, 256);

        repeat (3) @(posedge clk);
        #1 check("final_out_valid", bus.out_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
